// File: rtl/pwm_decoder_if.sv
// Signal bundle for pwm_decoder: measurement control in, measurement results out.
interface pwm_decoder_if #(
    parameter int unsigned COUNT_NBITS = 8
) ();
    logic                   en;
    logic                   pwm_in;
    logic [COUNT_NBITS-1:0] high_cycles;
    logic [COUNT_NBITS-1:0] period_cycles;
    logic                   valid;
    logic                   timeout;

    modport master (
        output en, pwm_in,
        input  high_cycles, period_cycles, valid, timeout
    );

    modport slave (
        input  en, pwm_in,
        output high_cycles, period_cycles, valid, timeout
    );
endinterface

// File: rtl/pwm_decoder.sv
// Measures PWM high time and period (rise to rise) in clk cycles; constant inputs report via timeout.
// Optional PWM_DECODER_GLITCH_FILTER_EN adds a 2-cycle stability filter ahead of the edge detector.
module pwm_decoder #(
    parameter int unsigned COUNT_NBITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_decoder_if.slave  bus
);
    localparam logic [COUNT_NBITS-1:0] CntMax  = '1;
    localparam logic [COUNT_NBITS-1:0] CntZero = '0;
    localparam logic [COUNT_NBITS-1:0] CntOne  = {{(COUNT_NBITS-1){1'b0}}, 1'b1};

    typedef enum logic {StIdle, StMeasure} state_e;

    logic sync1_q, sync2_q, pwm_d_q;
    logic pwm_s, rise;

    state_e                 state_q, state_d;
    logic [COUNT_NBITS-1:0] period_cnt_q, period_cnt_d;
    logic [COUNT_NBITS-1:0] high_cnt_q, high_cnt_d;
    logic [COUNT_NBITS-1:0] idle_cnt_q, idle_cnt_d;
    logic [COUNT_NBITS-1:0] high_cycles_q, high_cycles_d;
    logic [COUNT_NBITS-1:0] period_cycles_q, period_cycles_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic sync3_q;

    // pwm_d_q doubles as the filter state: follow the input only once it has held for two cycles.
    assign pwm_s = (sync2_q == sync3_q) ? sync2_q : pwm_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync3_q <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
        end
    end
`else
    assign pwm_s = sync2_q;
`endif

    assign rise = pwm_s & ~pwm_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= bus.pwm_in;
            sync2_q <= sync1_q;
            pwm_d_q <= pwm_s;
        end
    end

    always_comb begin
        state_d         = state_q;
        period_cnt_d    = period_cnt_q;
        high_cnt_d      = high_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        high_cycles_d   = high_cycles_q;
        period_cycles_d = period_cycles_q;
        timeout_d       = timeout_q;
        valid_d         = 1'b0;

        if (!bus.en) begin
            state_d      = StIdle;
            period_cnt_d = CntZero;
            high_cnt_d   = CntZero;
            idle_cnt_d   = CntZero;
        end else begin
            unique case (state_q)
                StIdle: begin
                    period_cnt_d = CntZero;
                    high_cnt_d   = CntZero;
                    if (rise) begin
                        state_d      = StMeasure;
                        period_cnt_d = CntOne;
                        high_cnt_d   = CntOne;
                        idle_cnt_d   = CntZero;
                    end else if (idle_cnt_q == CntMax) begin
                        period_cycles_d = CntMax;
                        high_cycles_d   = pwm_s ? CntMax : CntZero;
                        timeout_d       = 1'b1;
                        valid_d         = 1'b1;
                        idle_cnt_d      = CntOne;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CntOne;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        high_cycles_d   = high_cnt_q;
                        period_cycles_d = period_cnt_q;
                        timeout_d       = 1'b0;
                        valid_d         = 1'b1;
                        period_cnt_d    = CntOne;
                        high_cnt_d      = CntOne;
                    end else if (period_cnt_q == CntMax) begin
                        period_cycles_d = CntMax;
                        high_cycles_d   = pwm_s ? CntMax : CntZero;
                        timeout_d       = 1'b1;
                        valid_d         = 1'b1;
                        state_d         = StIdle;
                        period_cnt_d    = CntZero;
                        high_cnt_d      = CntZero;
                        // Keeps the re-report interval at CntMax cycles after this timeout.
                        idle_cnt_d      = CntOne;
                    end else begin
                        period_cnt_d = period_cnt_q + CntOne;
                        if (pwm_s) begin
                            high_cnt_d = high_cnt_q + CntOne;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            period_cnt_q    <= CntZero;
            high_cnt_q      <= CntZero;
            idle_cnt_q      <= CntZero;
            high_cycles_q   <= CntZero;
            period_cycles_q <= CntZero;
            valid_q         <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_cnt_q    <= period_cnt_d;
            high_cnt_q      <= high_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            high_cycles_q   <= high_cycles_d;
            period_cycles_q <= period_cycles_d;
            valid_q         <= valid_d;
            timeout_q       <= timeout_d;
        end
    end

    assign bus.high_cycles   = high_cycles_q;
    assign bus.period_cycles = period_cycles_q;
    assign bus.valid         = valid_q;
    assign bus.timeout       = timeout_q;
endmodule
